frequency_generator: RTL and testbench
======================================

# frequency_generator

Clock-rate generation block for the TFT/SPI peripheral. It buffers the master clock and derives a lower-rate square wave (`OutputCLK`) by integer division. It also counts output periods in a configurable counter (`Begin`..`End`, wrap or saturate) that sequences initialization data. All logic is synchronous to the single input clock; the divided clock is never used as a clock internally.

## Interface
Parameters:
- `INPUT_FREQ`, 50_000_000: master clock frequency in Hz.
- `frequency`, 10000: target `OutputCLK` frequency in Hz.
- `bitsNumber`, 26: width of the divider counter.
- `Begin`, 0: event counter start and reload value.
- `End`, 104: event counter terminal value. `End` ≥ `Begin`.
- `CountBits`, 25: event counter width.
- `mode`, 0: 0 = wrap to `Begin` after `End`; 1 = saturate at `End`.

Ports:
- `InputCLK`, in, 1: master clock.
- `reset`, in, 1: reset, asynchronous and active-high.
- `OutputCLK`, out, 1: divided clock, 50 % duty.
- `tick`, out, 1: one-`InputCLK` pulse coincident with each `OutputCLK` rising transition.
- `count`, out, `CountBits`: event counter value.
- `done`, out, 1: `count == End`, combinational.

## Operation
- Input buffer: `InputCLK` passes through a non-inverting buffer stage. Zero logical delay. All flops use the buffered clock.
- Half period: `HALF = INPUT_FREQ / (2*frequency)`, integer floor. If the result is below 1, clamp it to 1, giving `OutputCLK = InputCLK/2`. `HALF-1` must fit in `bitsNumber`; violating this is an elaboration error.
- Divider:
  - `div_cnt` increments on every edge.
  - When `div_cnt == HALF-1`: `div_cnt <= 0` and `OutputCLK <= ~OutputCLK`.
  - `tick <= 1` only on the edge where `OutputCLK` goes 0→1. Otherwise `tick <= 0`.
- Event counter, on an edge with `tick == 1`:
  - `mode 0`: `count <= (count == End) ? Begin : count+1`.
  - `mode 1`: `count <= (count == End) ? End : count+1`.
  - The counter is held while `tick == 0`.
- Reset values: `div_cnt = 0`, `OutputCLK = 0`, `tick = 0`, `count = Begin`. `done` therefore reflects `Begin == End`.
- Reset asserted mid-operation clears everything immediately (asynchronous). No partial `OutputCLK` high pulse survives.

## Timing
- The first `OutputCLK` rise is registered at the `HALF`-th `InputCLK` rising edge after reset deasserts. `tick` is high during the following cycle.
- `count` changes one cycle after `tick` is sampled high, i.e. `HALF+1` edges after reset for the first increment.
- `OutputCLK` period is `2*HALF` `InputCLK` cycles. `tick` period is the same.
- `done` follows `count` with no added latency.

## Configuration
- `FREQGEN_COUNTER_EN` defined: the event counter is present as described above.
- `FREQGEN_COUNTER_EN` undefined: the counter logic is omitted. `count` is tied to `Begin` and `done` is tied to 0. Divider and `tick` are unchanged.

## Structure
- Package `freqgen_pkg` contains:
  - `MODE_WRAP = 0` and `MODE_SATURATE = 1` constants.
  - Function `half_period(input_freq, freq)` that applies the floor and the clamp to 1.
- One sub-module, `tick_counter`, implements the event counter:
  - parameters `Begin`, `End`, `CountBits`, `mode`;
  - ports `InputCLK`, `reset`, `tick`, `count`, `done`.
- The divider and buffer stay in the top level.

## Test plan
- `INPUT_FREQ=100`, `frequency=10` (`HALF=5`), reset released → `OutputCLK` rises at edge 5, falls at edge 10, rises at edge 15. `tick` is high only in the cycles after edges 5, 15, 25.
- `INPUT_FREQ=100`, `frequency=100` (`HALF` clamps to 1) → `OutputCLK` toggles every edge (period 2). `tick` is high every other cycle.
- `mode=0`, `Begin=0`, `End=3`, `HALF=2` → `count` sequence 0,1,2,3,0,1. `done` is high only while `count == 3`.
- `mode=1`, `Begin=2`, `End=4` → `count` sequence 2,3,4,4,4. `done` stays high once 4 is reached.
- Reset asserted asynchronously mid-count (`count=2`, `OutputCLK=1`) → immediately `count=Begin`, `OutputCLK=0`, `tick=0`. After release, timing restarts exactly as in the first scenario.
- Build without `FREQGEN_COUNTER_EN` → `count == Begin` and `done == 0` for the whole run. `OutputCLK` matches the first scenario.

Source files
------------

// File: rtl/freqgen_pkg.sv
// Shared constants and helpers for the frequency generator.
// Provides counter mode encodings and the half-period calculation.
package freqgen_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // Floor of input_freq / (2*freq), never less than one cycle.
  function automatic int unsigned half_period(
    input int unsigned input_freq,
    input int unsigned freq
  );
    int unsigned h;
    if (freq == 0) begin
      h = 1;
    end else begin
      h = input_freq / (2 * freq);
    end
    if (h < 1) begin
      h = 1;
    end
    return h;
  endfunction

endpackage

// File: rtl/frequency_generator_tick_counter.sv
// Event counter advanced by the divider tick; wraps or saturates at End.
// Ports: InputCLK, reset (async, high), tick, count[CountBits], done.
module tick_counter
  import freqgen_pkg::*;
#(
  parameter int Begin     = 0,
  parameter int End       = 104,
  parameter int CountBits = 25,
  parameter int mode      = MODE_WRAP
) (
  input  logic                 InputCLK,
  input  logic                 reset,
  input  logic                 tick,
  output logic [CountBits-1:0] count,
  output logic                 done
);

  localparam logic [CountBits-1:0] BEG = CountBits'(Begin);
  localparam logic [CountBits-1:0] FIN = CountBits'(End);

  logic [CountBits-1:0] r_count;
  logic                 w_at_end;

  assign w_at_end = (r_count == FIN);

  always_ff @(posedge InputCLK or posedge reset) begin
    if (reset) begin
      r_count <= BEG;
    end else if (tick) begin
      if (w_at_end) begin
        r_count <= (mode == MODE_SATURATE) ? FIN : BEG;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count = r_count;
  assign done  = w_at_end;

endmodule

// File: rtl/frequency_generator.sv
// Integer clock divider with tick pulse and optional event counter.
// Ports: InputCLK, reset (async, high) -> OutputCLK, tick, count, done.
// Macro FREQGEN_COUNTER_EN enables the event counter.
module frequency_generator
  import freqgen_pkg::*;
#(
  parameter int INPUT_FREQ = 50_000_000,
  parameter int frequency  = 10000,
  parameter int bitsNumber = 26,
  parameter int Begin      = 0,
  parameter int End        = 104,
  parameter int CountBits  = 25,
  parameter int mode       = MODE_WRAP
) (
  input  logic                 InputCLK,
  input  logic                 reset,
  output logic                 OutputCLK,
  output logic                 tick,
  output logic [CountBits-1:0] count,
  output logic                 done
);

  localparam int unsigned HALF =
    half_period(INPUT_FREQ, frequency);
  localparam logic [bitsNumber-1:0] LAST =
    bitsNumber'(HALF - 1);

  if (((HALF - 1) >> bitsNumber) != 0) begin : g_bad_width
    $error("HALF-1 does not fit in bitsNumber");
  end
  if (End < Begin) begin : g_bad_range
    $error("End must be >= Begin");
  end
  if (mode != MODE_WRAP && mode != MODE_SATURATE) begin : g_bad_mode
    $error("mode must be 0 or 1");
  end

  // Non-inverting clock buffer; every flop runs from w_clk.
  logic w_clk;
  assign w_clk = InputCLK;

  logic [bitsNumber-1:0] r_div;
  logic                  r_out;
  logic                  r_tick;
  logic                  w_wrap;

  assign w_wrap = (r_div == LAST);

  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_out  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_div <= '0;
        r_out <= ~r_out;
      end else begin
        r_div <= r_div + 1'b1;
      end
      // Pulse only on the low-to-high toggle.
      r_tick <= w_wrap & ~r_out;
    end
  end

  assign OutputCLK = r_out;
  assign tick      = r_tick;

`ifdef FREQGEN_COUNTER_EN
  tick_counter #(
    .Begin    (Begin),
    .End      (End),
    .CountBits(CountBits),
    .mode     (mode)
  ) u_cnt (
    .InputCLK(w_clk),
    .reset   (reset),
    .tick    (r_tick),
    .count   (count),
    .done    (done)
  );
`else
  assign count = CountBits'(Begin);
  assign done  = 1'b0;
`endif

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator and tick_counter.
// Table vectors plus reset and counter corner sequences.
module tb_frequency_generator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tk  = 1'b0;

  always #5 clk = ~clk;

  logic       a_clk, a_tick, a_done;
  logic [3:0] a_cnt;
  logic       b_clk, b_tick, b_done;
  logic [1:0] b_cnt;
  logic       c_clk, c_tick, c_done;
  logic [3:0] c_cnt;
  logic       d_clk, d_tick, d_done;
  logic [3:0] d_cnt;
  logic [3:0] w_cnt, s_cnt;
  logic       w_done, s_done;

  frequency_generator #(
    .INPUT_FREQ(100), .frequency(10), .bitsNumber(4),
    .Begin(0), .End(3), .CountBits(4), .mode(0)
  ) u_a (
    .InputCLK(clk), .reset(rst), .OutputCLK(a_clk),
    .tick(a_tick), .count(a_cnt), .done(a_done)
  );

  frequency_generator #(
    .INPUT_FREQ(100), .frequency(100), .bitsNumber(1),
    .Begin(0), .End(1), .CountBits(2), .mode(0)
  ) u_b (
    .InputCLK(clk), .reset(rst), .OutputCLK(b_clk),
    .tick(b_tick), .count(b_cnt), .done(b_done)
  );

  frequency_generator #(
    .INPUT_FREQ(100), .frequency(25), .bitsNumber(2),
    .Begin(0), .End(3), .CountBits(4), .mode(0)
  ) u_c (
    .InputCLK(clk), .reset(rst), .OutputCLK(c_clk),
    .tick(c_tick), .count(c_cnt), .done(c_done)
  );

  frequency_generator #(
    .INPUT_FREQ(100), .frequency(25), .bitsNumber(2),
    .Begin(2), .End(4), .CountBits(4), .mode(1)
  ) u_d (
    .InputCLK(clk), .reset(rst), .OutputCLK(d_clk),
    .tick(d_tick), .count(d_cnt), .done(d_done)
  );

  tick_counter #(
    .Begin(0), .End(3), .CountBits(4), .mode(0)
  ) u_tw (
    .InputCLK(clk), .reset(rst), .tick(tk),
    .count(w_cnt), .done(w_done)
  );

  tick_counter #(
    .Begin(2), .End(4), .CountBits(4), .mode(1)
  ) u_ts (
    .InputCLK(clk), .reset(rst), .tick(tk),
    .count(s_cnt), .done(s_done)
  );

  typedef struct {
    int   n;
    logic oclk;
    logic otick;
  } vec_t;

  typedef struct {
    logic       t;
    logic [3:0] cw;
    logic       dw;
    logic [3:0] cs;
    logic       ds;
  } tcv_t;

  vec_t va[12];
  tcv_t vt[6];

  int checks = 0;
  int errors = 0;
  int n = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0d expected %0d",
               nm, n, act, exp);
    end
  endtask

  // Checks applied after every edge: HALF=1 toggling and
  // the HALF=2 counter instances.
  task automatic check_every();
    int k, ec, ed, sc, sd;
    chk("b_clk", 32'(b_clk), 32'(n % 2));
    chk("b_tick", 32'(b_tick), 32'(n % 2));
    k = (n >= 3) ? ((n - 3) / 4 + 1) : 0;
`ifdef FREQGEN_COUNTER_EN
    ec = k % 4;
    ed = (ec == 3) ? 1 : 0;
    sc = (2 + k > 4) ? 4 : 2 + k;
    sd = (sc == 4) ? 1 : 0;
`else
    ec = 0;
    ed = 0;
    sc = 2;
    sd = 0;
`endif
    chk("c_count", 32'(c_cnt), 32'(ec));
    chk("c_done", 32'(c_done), 32'(ed));
    chk("d_count", 32'(d_cnt), 32'(sc));
    chk("d_done", 32'(d_done), 32'(sd));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    check_every();
  endtask

  task automatic run_table();
    n = 0;
    check_every();
    for (int i = 0; i < 12; i++) begin
      while (n < va[i].n) step();
      chk("a_clk", 32'(a_clk), 32'(va[i].oclk));
      chk("a_tick", 32'(a_tick), 32'(va[i].otick));
    end
  endtask

  initial begin
    va[0]  = '{0, 0, 0};
    va[1]  = '{4, 0, 0};
    va[2]  = '{5, 1, 1};
    va[3]  = '{6, 1, 0};
    va[4]  = '{9, 1, 0};
    va[5]  = '{10, 0, 0};
    va[6]  = '{14, 0, 0};
    va[7]  = '{15, 1, 1};
    va[8]  = '{16, 1, 0};
    va[9]  = '{20, 0, 0};
    va[10] = '{25, 1, 1};
    va[11] = '{26, 1, 0};

    vt[0] = '{1, 4'd1, 0, 4'd3, 0};
    vt[1] = '{1, 4'd2, 0, 4'd4, 1};
    vt[2] = '{0, 4'd2, 0, 4'd4, 1};
    vt[3] = '{1, 4'd3, 1, 4'd4, 1};
    vt[4] = '{1, 4'd0, 0, 4'd4, 1};
    vt[5] = '{1, 4'd1, 0, 4'd4, 1};

    #1 rst = 1'b1;
    #1;
    n = 0;
    chk("rst_a_clk", 32'(a_clk), 32'd0);
    chk("rst_a_tick", 32'(a_tick), 32'd0);
    chk("rst_w_count", 32'(w_cnt), 32'd0);
    chk("rst_w_done", 32'(w_done), 32'd0);
    chk("rst_s_count", 32'(s_cnt), 32'd2);
    chk("rst_s_done", 32'(s_done), 32'd0);
    check_every();

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tk = vt[i].t;
      @(posedge clk);
      #1;
      chk("tw_count", 32'(w_cnt), 32'(vt[i].cw));
      chk("tw_done", 32'(w_done), 32'(vt[i].dw));
      chk("ts_count", 32'(s_cnt), 32'(vt[i].cs));
      chk("ts_done", 32'(s_done), 32'(vt[i].ds));
      @(negedge clk);
    end
    tk = 1'b0;

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_table();

    // Mid-count asynchronous reset, away from any clock edge.
    chk("pre_a_clk", 32'(a_clk), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_a_clk", 32'(a_clk), 32'd0);
    chk("ar_a_tick", 32'(a_tick), 32'd0);
    chk("ar_c_count", 32'(c_cnt), 32'd0);
    chk("ar_c_done", 32'(c_done), 32'd0);
    chk("ar_d_count", 32'(d_cnt), 32'd2);
    @(negedge clk);
    rst = 1'b0;
    run_table();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
